// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. Port A is a fixed-priority writeback path.
// Port B feeds a skid FIFO. A busy scoreboard tracks in-flight multi-cycle destinations.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        a_we,
    input  logic [4:0]  a_wn,
    input  logic [31:0] a_d,
    input  logic        a_jal,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_wn,
    input  logic [31:0] b_d,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  q_rna,
    input  logic [4:0]  q_rnb,
    output logic        busy_a,
    output logic        busy_b,
    output logic        stall_a,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d,
    output logic        rf_jal,
    output logic        err_collision
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_fifo_wn [FIFO_DEPTH];
    logic [31:0]   r_fifo_d  [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [NW-1:0] r_count;
    logic [31:0]   r_busy;
    logic [CW-1:0] r_cnt;
    logic          r_stall;
    logic          r_err;

    logic          w_a_eff;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [4:0]    w_head_wn;
    logic [31:0]   w_head_d;
    logic [31:0]   w_busy_nxt;

    assign w_a_eff   = a_we && (a_wn != 5'd0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == NW'(FIFO_DEPTH));
    assign w_pop     = !w_a_eff && !w_empty;
    assign b_ready   = !w_full || w_pop;
    // A push to r0 completes the handshake but never occupies a slot.
    assign w_push    = b_valid && b_ready && (b_wn != 5'd0);
    assign w_head_wn = r_fifo_wn[r_rd_ptr];
    assign w_head_d  = r_fifo_d[r_rd_ptr];

    always_comb begin
        rf_we  = 1'b0;
        rf_wn  = '0;
        rf_d   = '0;
        rf_jal = 1'b0;
        if (w_a_eff) begin
            rf_we  = 1'b1;
            rf_wn  = a_wn;
            rf_d   = a_d;
            rf_jal = a_jal;
        end else if (!w_empty) begin
            rf_we  = 1'b1;
            rf_wn  = w_head_wn;
            rf_d   = w_head_d;
        end
    end

    // Storage is not reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wn[r_wr_ptr] <= b_wn;
            r_fifo_d[r_wr_ptr]  <= b_d;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear is applied before set so a same-cycle issue keeps the bit high.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)       w_busy_nxt[w_head_wn] = 1'b0;
        if (issue_valid) w_busy_nxt[issue_rd]  = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_a = r_busy[q_rna];
    assign busy_b = r_busy[q_rnb];

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop || w_empty) begin
                r_cnt <= '0;
            end else if (r_cnt != CW'(STARVE_LIMIT)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_pop) begin
                r_stall <= 1'b0;
            end else if (r_cnt == CW'(STARVE_LIMIT - 1)) begin
                r_stall <= 1'b1;
            end

            if (w_a_eff && r_stall) r_err <= 1'b1;
        end
    end

    assign stall_a       = r_stall;
    assign err_collision = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios, then random traffic,
// all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        clrn;
    logic        a_we;
    logic [4:0]  a_wn;
    logic [31:0] a_d;
    logic        a_jal;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wn;
    logic [31:0] b_d;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  q_rna;
    logic [4:0]  q_rnb;
    logic        busy_a;
    logic        busy_b;
    logic        stall_a;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic        rf_jal;
    logic        err_collision;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .clrn(clrn),
        .a_we(a_we), .a_wn(a_wn), .a_d(a_d), .a_jal(a_jal),
        .b_valid(b_valid), .b_ready(b_ready), .b_wn(b_wn), .b_d(b_d),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .q_rna(q_rna), .q_rnb(q_rnb), .busy_a(busy_a), .busy_b(busy_b),
        .stall_a(stall_a),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .rf_jal(rf_jal),
        .err_collision(err_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending port-B results in arrival order, plus busy set and starvation state.
    bit [4:0]  m_wn[$];
    bit [31:0] m_d[$];
    bit [31:0] m_busy;
    int        m_cnt;
    bit        m_stall;
    bit        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wn.delete();
        m_d.delete();
        m_busy  = '0;
        m_cnt   = 0;
        m_stall = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic bit a_effective();
        return a_we && (a_wn != 5'd0);
    endfunction

    task automatic model_check();
        bit        a_eff;
        bit        nonempty;
        bit        e_we;
        bit [4:0]  e_wn;
        bit [31:0] e_d;
        bit        e_jal;
        bit        e_ready;
        a_eff    = a_effective();
        nonempty = (m_wn.size() > 0);
        e_we  = a_eff || nonempty;
        e_wn  = a_eff ? a_wn : (nonempty ? m_wn[0] : 5'd0);
        e_d   = a_eff ? a_d  : (nonempty ? m_d[0]  : 32'd0);
        e_jal = a_eff ? a_jal : 1'b0;
        e_ready = (m_wn.size() < DEPTH) || (!a_eff && nonempty);
        chk("rf_we",   32'(rf_we),   32'(e_we));
        chk("rf_wn",   32'(rf_wn),   32'(e_wn));
        chk("rf_d",    rf_d,         e_d);
        chk("rf_jal",  32'(rf_jal),  32'(e_jal));
        chk("b_ready", 32'(b_ready), 32'(e_ready));
        chk("busy_a",  32'(busy_a),  32'(m_busy[q_rna]));
        chk("busy_b",  32'(busy_b),  32'(m_busy[q_rnb]));
        chk("stall_a", 32'(stall_a), 32'(m_stall));
        chk("err_collision", 32'(err_collision), 32'(m_err));
    endtask

    task automatic model_step();
        bit       a_eff;
        bit       pop;
        bit       ready;
        int       size_before;
        bit [4:0] w;
        bit [31:0] dd;
        a_eff       = a_effective();
        size_before = m_wn.size();
        pop         = !a_eff && (size_before > 0);
        ready       = (size_before < DEPTH) || pop;
        if (pop) begin
            w  = m_wn.pop_front();
            dd = m_d.pop_front();
            m_busy[w] = 1'b0;
        end
        if (b_valid && ready && b_wn != 5'd0) begin
            m_wn.push_back(b_wn);
            m_d.push_back(b_d);
        end
        if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        if (a_eff && m_stall) m_err = 1'b1;
        if (pop) m_stall = 1'b0;
        else if (m_cnt == LIMIT - 1) m_stall = 1'b1;
        if (pop || size_before == 0) m_cnt = 0;
        else if (m_cnt < LIMIT) m_cnt++;
    endtask

    task automatic settle();
        #4;
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        a_we = 0; a_wn = 0; a_d = 0; a_jal = 0;
        b_valid = 0; b_wn = 0; b_d = 0;
        issue_valid = 0; issue_rd = 0;
        q_rna = 0; q_rnb = 0;
    endtask

    initial begin
        idle_inputs();
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we",   32'(rf_we),   32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_stall",   32'(stall_a), 32'd0);
        chk("rst_err",     32'(err_collision), 32'd0);
        clrn = 1'b0;
        model_reset();

        // Idle
        repeat (3) begin
            settle();
            chk("idle_rf_we", 32'(rf_we), 32'd0);
            chk("idle_busy",  32'({busy_a, busy_b}), 32'd0);
            advance();
        end

        // Port A pass-through
        a_we = 1; a_wn = 5; a_d = 32'h1234_5678; a_jal = 1;
        settle();
        chk("a_pass_we",  32'(rf_we),  32'd1);
        chk("a_pass_wn",  32'(rf_wn),  32'd5);
        chk("a_pass_d",   rf_d,        32'h1234_5678);
        chk("a_pass_jal", 32'(rf_jal), 32'd1);
        advance();
        a_wn = 0;
        settle();
        chk("a_r0_we", 32'(rf_we), 32'd0);
        advance();
        idle_inputs();

        // B drain path for r7
        issue_valid = 1; issue_rd = 7; q_rna = 7;
        settle();
        chk("b7_noforward", 32'(busy_a), 32'd0);
        advance();
        issue_valid = 0;
        settle();
        chk("b7_busy_c1", 32'(busy_a), 32'd1);
        advance();
        cyc();
        b_valid = 1; b_wn = 7; b_d = 32'hCAFE;
        settle();
        chk("b7_ready", 32'(b_ready), 32'd1);
        chk("b7_nobypass", 32'(rf_we), 32'd0);
        advance();
        b_valid = 0;
        settle();
        chk("b7_we",  32'(rf_we),  32'd1);
        chk("b7_wn",  32'(rf_wn),  32'd7);
        chk("b7_d",   rf_d,        32'hCAFE);
        chk("b7_jal", 32'(rf_jal), 32'd0);
        chk("b7_busy_c4", 32'(busy_a), 32'd1);
        advance();
        settle();
        chk("b7_busy_c5", 32'(busy_a), 32'd0);
        advance();

        // Contention, full FIFO, starvation, then drain
        q_rna = 10; q_rnb = 12;
        issue_valid = 1;
        issue_rd = 10; cyc();
        issue_rd = 11; cyc();
        issue_rd = 12; cyc();
        issue_valid = 0;
        a_we = 1; a_wn = 3; a_d = 32'hA0A0_0001; a_jal = 0;
        b_valid = 1; b_wn = 10; b_d = 32'h1010;
        settle(); chk("cont_push1", 32'(b_ready), 32'd1); advance();
        b_wn = 11; b_d = 32'h1111;
        settle(); chk("cont_push2", 32'(b_ready), 32'd1); advance();
        b_wn = 12; b_d = 32'h1212;
        settle(); chk("cont_full", 32'(b_ready), 32'd0); advance();
        settle(); chk("starve_c3", 32'(stall_a), 32'd0); advance();
        settle(); chk("starve_c4", 32'(stall_a), 32'd0); advance();
        a_we = 0;
        settle();
        chk("starve_set",  32'(stall_a), 32'd1);
        chk("drain0_wn",   32'(rf_wn),   32'd10);
        chk("drain0_d",    rf_d,         32'h1010);
        chk("full_pop_ready", 32'(b_ready), 32'd1);
        advance();
        b_valid = 0;
        settle();
        chk("starve_clr", 32'(stall_a), 32'd0);
        chk("drain1_wn",  32'(rf_wn),   32'd11);
        advance();
        settle();
        chk("drain2_wn", 32'(rf_wn), 32'd12);
        chk("drain_busy10", 32'(busy_a), 32'd0);
        advance();
        settle();
        chk("drain_empty", 32'(rf_we), 32'd0);
        chk("drain_busy12", 32'(busy_b), 32'd0);
        chk("no_collision", 32'(err_collision), 32'd0);
        advance();
        idle_inputs();

        // Same-cycle issue and pop of r9: set wins
        issue_valid = 1; issue_rd = 9; cyc();
        issue_valid = 0;
        b_valid = 1; b_wn = 9; b_d = 32'h99; cyc();
        b_valid = 0;
        issue_valid = 1; issue_rd = 9;
        settle(); chk("r9_pop_wn", 32'(rf_wn), 32'd9); advance();
        issue_valid = 0; q_rna = 9;
        settle(); chk("r9_busy_kept", 32'(busy_a), 32'd1); advance();

        // Push to r0 is accepted and dropped
        b_valid = 1; b_wn = 0; b_d = 32'hFFFF;
        settle(); chk("r0_push_ready", 32'(b_ready), 32'd1); advance();
        b_valid = 0;
        settle(); chk("r0_push_dropped", 32'(rf_we), 32'd0); advance();

        // Collision during stall, then asynchronous reset with two entries queued
        issue_valid = 1;
        issue_rd = 13; cyc();
        issue_rd = 14; cyc();
        issue_valid = 0; q_rna = 13; q_rnb = 14;
        a_we = 1; a_wn = 4; a_d = 32'h44;
        b_valid = 1; b_wn = 13; b_d = 32'h1313; cyc();
        b_wn = 14; b_d = 32'h1414; cyc();
        b_valid = 0;
        repeat (3) cyc();
        settle();
        chk("coll_stall", 32'(stall_a), 32'd1);
        chk("coll_err_pre", 32'(err_collision), 32'd0);
        chk("coll_a_wins", 32'(rf_wn), 32'd4);
        advance();
        a_we = 0;
        settle();
        chk("coll_err", 32'(err_collision), 32'd1);
        clrn = 1'b1;
        #1;
        chk("arst_rf_we", 32'(rf_we),   32'd0);
        chk("arst_stall", 32'(stall_a), 32'd0);
        chk("arst_err",   32'(err_collision), 32'd0);
        chk("arst_busy",  32'({busy_a, busy_b}), 32'd0);
        chk("arst_ready", 32'(b_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        clrn = 1'b0;
        settle();
        chk("arst_lost", 32'(rf_we), 32'd0);
        advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            a_we  = m_stall ? ($urandom_range(7) == 0) : ($urandom_range(2) != 0);
            a_wn  = 5'($urandom_range(31));
            a_d   = $urandom;
            a_jal = 1'($urandom_range(1));
            b_valid = ($urandom_range(2) == 0);
            b_wn  = 5'($urandom_range(31));
            b_d   = $urandom;
            issue_valid = ($urandom_range(2) == 0);
            issue_rd = 5'($urandom_range(31));
            q_rna = 5'($urandom_range(31));
            q_rnb = 5'($urandom_range(31));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
